// File: rtl/lift_door_pkg.sv
// Shared door types for the lift controllers: channel state encoding and counter width helper.
// Read by the door sequencer and by the floor/motion controllers that watch door state.
package lift_door_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_state_t;

  // Width of a counter that must hold 0..max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/door_sequencer_if.sv
// Door sequencer bundle: per-channel request levels in, per-channel door status and state out.
// All signals are levels sampled on posedge clk; there is no valid/ready pairing, a request simply
// holds for as long as the caller wants it honoured and status reflects the registered door state.
interface door_sequencer_if #(
  parameter int N_DOORS = 2
);
  logic [N_DOORS-1:0] open_req;
  logic [N_DOORS-1:0] close_req;
  logic [N_DOORS-1:0] hold;
  logic [N_DOORS-1:0] obstruct;
  logic [N_DOORS-1:0] door_open;
  logic [N_DOORS-1:0] door_closed;
  logic [N_DOORS-1:0] nudge;
  logic               all_closed;
  lift_door_pkg::door_state_t [N_DOORS-1:0] door_state;

  modport master (
    output open_req, close_req, hold, obstruct,
    input  door_open, door_closed, nudge, all_closed, door_state
  );

  modport slave (
    input  open_req, close_req, hold, obstruct,
    output door_open, door_closed, nudge, all_closed, door_state
  );
endinterface

// File: rtl/door_channel_fsm.sv
// One door channel: open/dwell/close FSM with modelled position and obstruction reversal.
// DOOR_NUDGE_EN adds the reopen counter and the slow, non-reversing nudge close.
module door_channel_fsm
  import lift_door_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DWELL_CYCLES  = 200,
  parameter int MAX_REOPENS   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        open_req,
  input  logic        close_req,
  input  logic        hold,
  input  logic        obstruct,
  output logic        door_open,
  output logic        door_closed,
  output logic        nudge,
  output door_state_t state
);

  localparam int POS_W   = cnt_w(TRAVEL_CYCLES);
  localparam int DWELL_W = cnt_w(DWELL_CYCLES);
  localparam logic [POS_W-1:0]   POS_FULL   = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(TRAVEL_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_FULL = DWELL_W'(DWELL_CYCLES);

  if (TRAVEL_CYCLES < 1 || DWELL_CYCLES < 1 || MAX_REOPENS < 0) begin : g_bad_cfg
    $error("door_channel_fsm: TRAVEL_CYCLES and DWELL_CYCLES must be >= 1, MAX_REOPENS >= 0");
  end

  door_state_t          state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
`ifdef DOOR_NUDGE_EN
  localparam int RC_W = cnt_w(MAX_REOPENS);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_REOPENS);
  logic [RC_W-1:0] reopen_q, reopen_d;
  logic            nudge_q, nudge_d;
  logic            step_q, step_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLOSED;
      pos_q    <= '0;
      dwell_q  <= '0;
`ifdef DOOR_NUDGE_EN
      reopen_q <= '0;
      nudge_q  <= 1'b0;
      step_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dwell_q  <= dwell_d;
`ifdef DOOR_NUDGE_EN
      reopen_q <= reopen_d;
      nudge_q  <= nudge_d;
      step_q   <= step_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dwell_d  = dwell_q;
`ifdef DOOR_NUDGE_EN
    reopen_d = reopen_q;
    nudge_d  = nudge_q;
    step_d   = step_q;
`endif
    case (state_q)
      CLOSED: begin
        if (open_req) begin
          state_d = OPENING;
          pos_d   = '0;
        end
      end
      OPENING: begin
        // >= also covers a reversal taken before the door left the fully open position.
        if (pos_q >= POS_LAST) begin
          state_d = OPEN;
          pos_d   = POS_FULL;
          dwell_d = DWELL_FULL;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end
      OPEN: begin
        if (open_req || hold) begin
          dwell_d = DWELL_FULL;
        end else if (close_req || dwell_q <= DWELL_W'(1)) begin
          state_d = CLOSING;
`ifdef DOOR_NUDGE_EN
          nudge_d = (reopen_q >= RC_MAX);
          step_d  = 1'b0;
`endif
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      CLOSING: begin
`ifdef DOOR_NUDGE_EN
        if (nudge_q) begin
          // Half-speed close: position moves on every second cycle, reversal inputs ignored.
          step_d = ~step_q;
          if (step_q) begin
            if (pos_q <= POS_W'(1)) begin
              state_d  = CLOSED;
              pos_d    = '0;
              reopen_d = '0;
              nudge_d  = 1'b0;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end else
`endif
        if (obstruct || open_req) begin
          state_d = OPENING;
`ifdef DOOR_NUDGE_EN
          if (obstruct && reopen_q < RC_MAX) reopen_d = reopen_q + RC_W'(1);
`endif
        end else if (pos_q <= POS_W'(1)) begin
          state_d = CLOSED;
          pos_d   = '0;
`ifdef DOOR_NUDGE_EN
          reopen_d = '0;
`endif
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end
      default: begin
        state_d = CLOSED;
        pos_d   = '0;
      end
    endcase
  end

  assign state       = state_q;
  assign door_open   = (state_q == OPEN);
  assign door_closed = (state_q == CLOSED);
`ifdef DOOR_NUDGE_EN
  assign nudge = nudge_q;
`else
  assign nudge = 1'b0;
`endif

endmodule

// File: rtl/door_sequencer.sv
// N independent door channels; all_closed is the car-motion interlock.
// Optional DOOR_NUDGE_EN build enables nudge close after repeated obstruction reversals.
module door_sequencer #(
  parameter int N_DOORS       = 2,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DWELL_CYCLES  = 200,
  parameter int MAX_REOPENS   = 3
) (
  input logic              clk,
  input logic              reset,
  door_sequencer_if.slave  dif
);

  for (genvar i = 0; i < N_DOORS; i++) begin : g_ch
    door_channel_fsm #(
      .TRAVEL_CYCLES (TRAVEL_CYCLES),
      .DWELL_CYCLES  (DWELL_CYCLES),
      .MAX_REOPENS   (MAX_REOPENS)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .open_req    (dif.open_req[i]),
      .close_req   (dif.close_req[i]),
      .hold        (dif.hold[i]),
      .obstruct    (dif.obstruct[i]),
      .door_open   (dif.door_open[i]),
      .door_closed (dif.door_closed[i]),
      .nudge       (dif.nudge[i]),
      .state       (dif.door_state[i])
    );
  end

  assign dif.all_closed = &dif.door_closed;

endmodule
